// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a 16x8 synchronous RAM; read data is steered back to its issuer.
// Optional `RAM_ARB_CLEAR_EN adds a clr_start/clr_busy sequencer that zero-fills the whole RAM.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic                  a_rsp_valid,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_wr_enable,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enable,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
`ifdef RAM_ARB_CLEAR_EN
  input  logic                  clr_start,
  output logic                  clr_busy,
`endif
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  logic [1:0]            req_valid;
  logic [1:0]            req_write;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  assign req_valid    = {b_valid, a_valid};
  assign req_write    = {b_write, a_write};
  assign req_addr[0]  = a_addr;
  assign req_addr[1]  = b_addr;
  assign req_wdata[0] = a_wdata;
  assign req_wdata[1] = b_wdata;

  logic       arb_enable;
  logic [1:0] grant;
  logic       grant_any;
  logic       grant_sel;
  logic       last_grant_q, last_grant_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == ADDR_LAST) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end
    endcase
  end

  assign clearing   = (state_q == ST_CLEAR);
  assign clr_busy   = clearing;
  // The clr_start cycle itself is still in IDLE, so a request granted then completes normally.
  assign arb_enable = ~rst & ~clearing;
`else
  assign arb_enable = ~rst;
`endif

  // Under contention the requester that did not win last time takes the slot.
  always_comb begin
    grant = 2'b00;
    if (arb_enable) begin
      if (req_valid == 2'b11) begin
        grant = (last_grant_q == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign grant_any = |grant;
  assign grant_sel = grant[1];
  assign a_ready   = grant[0];
  assign b_ready   = grant[1];

  always_comb begin
    ram_wr_enable = 1'b0;
    ram_wr_addr   = '0;
    ram_wr_data   = '0;
    ram_rd_enable = 1'b0;
    ram_rd_addr   = '0;
    if (grant_any) begin
      if (req_write[grant_sel]) begin
        ram_wr_enable = 1'b1;
        ram_wr_addr   = req_addr[grant_sel] & ADDR_LAST;
        ram_wr_data   = req_wdata[grant_sel];
      end else begin
        ram_rd_enable = 1'b1;
        ram_rd_addr   = req_addr[grant_sel] & ADDR_LAST;
      end
    end
`ifdef RAM_ARB_CLEAR_EN
    if (clearing) begin
      ram_wr_enable = 1'b1;
      ram_wr_addr   = clr_addr_q;
      ram_wr_data   = '0;
    end
`endif
  end

  always_comb begin
    last_grant_d = grant_any ? grant_sel : last_grant_q;
    rsp_valid_d  = grant & ~req_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_B;
      rsp_valid_q  <= 2'b00;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // A read in flight when reset arrives must not produce a strobe during the reset cycle.
  assign a_rsp_valid = rsp_valid_q[0] & ~rst;
  assign b_rsp_valid = rsp_valid_q[1] & ~rst;
  assign rsp_data    = ram_rd_data;

endmodule
